counter_wrap_monitor: RTL

Downstream observer for the 10-bit up/down `counter` block: it samples the counter value and its `mode` input every cycle and detects wrap-around events (1023→0 up, 0→1023 down). It optionally flags illegal steps. Detected events are queued in a small FIFO and drained over a valid/ready port. A saturating wrap total is exported for status. It sits beside `counter` inside `tb_counter`-style harnesses and in the integrated design, and is fed directly from the counter's register outputs.

---
 rtl/counter_mon_pkg.sv | 18 +
 rtl/counter_mon_fifo.sv | 53 +++++
 rtl/counter_wrap_monitor.sv | 100 ++++++++++
 3 files changed

// File: rtl/counter_mon_pkg.sv
// Shared types for the counter wrap monitor: event type encoding and event record.
package counter_mon_pkg;

  localparam int CNT_W_DEF = 10;

  typedef enum logic [1:0] {
    EVT_NONE      = 2'b00,
    EVT_WRAP_UP   = 2'b01,
    EVT_WRAP_DOWN = 2'b10,
    EVT_STEP_ERR  = 2'b11
  } evt_type_e;

  typedef struct packed {
    evt_type_e              typ;
    logic [CNT_W_DEF-1:0]   cnt;
  } evt_t;

endpackage

// File: rtl/counter_mon_fifo.sv
// Synchronous FIFO with registered storage and no fall-through; push and pop each one per cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module counter_mon_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_wrap_monitor.sv
// Observes an up/down counter, queues wrap (and, with COUNTER_WRAP_MON_STEP_CHECK_EN, illegal-step)
// events one cycle after the offending sample; events drain over valid/ready, overflow drops and flags.
module counter_wrap_monitor
  import counter_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [CNT_W-1:0]  cnt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CNT_W+1:0]  evt_data,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              ovf,
  output logic              step_err
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [CNT_W-1:0] prev_cnt;
  logic             prev_mode;
  logic             prev_vld;
  logic             wrap_up;
  logic             wrap_dn;
  logic             bad_step;
  evt_type_e        evt_type;
  logic             evt_push;
  logic             evt_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             evt_drop;

  assign wrap_up = prev_vld &&  prev_mode && (prev_cnt == CNT_MAX) && (cnt == '0);
  assign wrap_dn = prev_vld && !prev_mode && (prev_cnt == '0)      && (cnt == CNT_MAX);

`ifdef COUNTER_WRAP_MON_STEP_CHECK_EN
  logic [CNT_W-1:0] exp_cnt;
  // Wraps fall out of the modular +/-1 naturally, so they never count as errors.
  assign exp_cnt  = prev_mode ? prev_cnt + CNT_W'(1) : prev_cnt - CNT_W'(1);
  assign bad_step = prev_vld && (cnt != exp_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           step_err <= 1'b0;
    else if (bad_step) step_err <= 1'b1;
  end
`else
  assign bad_step = 1'b0;
  assign step_err = 1'b0;
`endif

  always_comb begin
    evt_type = EVT_NONE;
    if (wrap_up)       evt_type = EVT_WRAP_UP;
    else if (wrap_dn)  evt_type = EVT_WRAP_DOWN;
    else if (bad_step) evt_type = EVT_STEP_ERR;
  end

  assign evt_push  = (evt_type != EVT_NONE);
  assign evt_valid = !fifo_empty;
  assign evt_pop   = evt_valid && evt_ready;
  assign evt_drop  = evt_push && fifo_full && !evt_pop;

  counter_mon_fifo #(
    .WIDTH (CNT_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (evt_push),
    .push_dat ({evt_type, cnt}),
    .pop      (evt_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (evt_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt   <= '0;
      prev_mode  <= 1'b0;
      prev_vld   <= 1'b0;
      wrap_total <= '0;
      ovf        <= 1'b0;
    end else begin
      prev_cnt  <= cnt;
      prev_mode <= mode;
      prev_vld  <= 1'b1;
      // Dropped wraps still count toward the total.
      if ((wrap_up || wrap_dn) && (wrap_total != WRAP_MAX))
        wrap_total <= wrap_total + WRAP_W'(1);
      if (evt_drop) ovf <= 1'b1;
    end
  end

endmodule
